// File: rtl/sorter.sv
// Streaming insertion sorter: loads ELEMENT_NUM words into a sorted array, then writes them out.
// Define SORTER_DESCEND_EN for descending order (address 0 = largest element).
module sorter #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ELEMENT_NUM      = 16,
    parameter int unsigned LOG2_ELEMENT_NUM = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        um_valid_i,
    input  logic [DATA_WIDTH-1:0]       um_data_i,
    output logic                        sm_valid_o,
    output logic [LOG2_ELEMENT_NUM-1:0] sm_addr_o,
    output logic [DATA_WIDTH-1:0]       sm_data_o,
    output logic                        done_o
);

    typedef enum logic [1:0] {StLoad, StWrite, StDone} state_e;

    localparam logic [LOG2_ELEMENT_NUM-1:0] LastIdx = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

    state_e                        state_q, state_d;
    logic [LOG2_ELEMENT_NUM-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]         arr_q [ELEMENT_NUM];
    logic [DATA_WIDTH-1:0]         arr_d [ELEMENT_NUM];
    logic [DATA_WIDTH-1:0]         ins   [ELEMENT_NUM];
    logic [ELEMENT_NUM-1:0]        keep;
    logic                          sm_valid_q, sm_valid_d;
    logic [LOG2_ELEMENT_NUM-1:0]   sm_addr_q, sm_addr_d;
    logic [DATA_WIDTH-1:0]         sm_data_q, sm_data_d;
    logic                          done_q, done_d;

    // keep[i]: entry i is occupied and stays ahead of the incoming word; keep is a prefix mask
    always_comb begin
        for (int i = 0; i < ELEMENT_NUM; i++) begin
`ifdef SORTER_DESCEND_EN
            keep[i] = (LOG2_ELEMENT_NUM'(i) < count_q) && (arr_q[i] >= um_data_i);
`else
            keep[i] = (LOG2_ELEMENT_NUM'(i) < count_q) && (arr_q[i] <= um_data_i);
`endif
        end
    end

    always_comb begin
        ins[0] = keep[0] ? arr_q[0] : um_data_i;
        for (int i = 1; i < ELEMENT_NUM; i++) begin
            if (keep[i]) begin
                ins[i] = arr_q[i];
            end else if (keep[i-1]) begin
                ins[i] = um_data_i;
            end else begin
                ins[i] = arr_q[i-1];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        arr_d      = arr_q;
        sm_valid_d = 1'b0;
        sm_addr_d  = sm_addr_q;
        sm_data_d  = sm_data_q;
        done_d     = done_q;
        case (state_q)
            StLoad: begin
                if (um_valid_i) begin
                    arr_d   = ins;
                    count_d = count_q + 1'b1;
                    if (count_q == LastIdx) begin
                        // First write is registered straight from the post-insert array
                        state_d    = StWrite;
                        sm_valid_d = 1'b1;
                        sm_addr_d  = '0;
                        sm_data_d  = ins[0];
                    end
                end
            end
            StWrite: begin
                if (sm_addr_q == LastIdx) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    sm_valid_d = 1'b1;
                    sm_addr_d  = sm_addr_q + 1'b1;
                    sm_data_d  = arr_q[sm_addr_d];
                end
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StLoad;
            count_q    <= '0;
            sm_valid_q <= 1'b0;
            sm_addr_q  <= '0;
            sm_data_q  <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < ELEMENT_NUM; i++) begin
                arr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sm_valid_q <= sm_valid_d;
            sm_addr_q  <= sm_addr_d;
            sm_data_q  <= sm_data_d;
            done_q     <= done_d;
            for (int i = 0; i < ELEMENT_NUM; i++) begin
                arr_q[i] <= arr_d[i];
            end
        end
    end

    assign sm_valid_o = sm_valid_q;
    assign sm_addr_o  = sm_addr_q;
    assign sm_data_o  = sm_data_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_sorter.sv
// Scoreboard bench for sorter: expected sorted words are queued at stimulus time, popped per write.
module tb_sorter;

    localparam int N = 16;
`ifdef SORTER_DESCEND_EN
    localparam bit Desc = 1'b1;
`else
    localparam bit Desc = 1'b0;
`endif

    typedef logic [31:0] vec_t [N];

    logic        clk;
    logic        rst_n;
    logic        um_valid;
    logic [31:0] um_data;
    logic        sm_valid;
    logic [3:0]  sm_addr;
    logic [31:0] sm_data;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    sorter #(
        .DATA_WIDTH       (32),
        .ELEMENT_NUM      (16),
        .LOG2_ELEMENT_NUM (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .um_valid_i (um_valid),
        .um_data_i  (um_data),
        .sm_valid_o (sm_valid),
        .sm_addr_o  (sm_addr),
        .sm_data_o  (sm_data),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ascending insertion sort, reversed for the descending build
    task automatic model_sort(input vec_t v, output vec_t s);
        vec_t a;
        logic [31:0] t;
        a = v;
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        end
        for (int k = 0; k < N; k++) s[k] = Desc ? a[N-1-k] : a[k];
    endtask

    task automatic push_expected(input vec_t asc_or_any, input bit presorted_asc);
        vec_t s;
        if (presorted_asc) begin
            for (int k = 0; k < N; k++) s[k] = Desc ? asc_or_any[N-1-k] : asc_or_any[k];
        end else begin
            model_sort(asc_or_any, s);
        end
        for (int k = 0; k < N; k++) exp_q.push_back(s[k]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        um_valid = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drive_job(input vec_t v, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && i > 0) begin
                @(negedge clk);
                um_valid = 1'b0;
                um_data  = $urandom;
                @(posedge clk);
            end
            @(negedge clk);
            um_valid = 1'b1;
            um_data  = v[i];
            @(posedge clk);
        end
    endtask

    // Runs from the edge of the last accept: 16 writes, then done
    task automatic collect(input bit extra_pulses);
        logic [31:0] e;
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk);
            um_valid = extra_pulses ? c[0] : 1'b0;
            um_data  = $urandom;
            if (c <= N) begin
                checks++;
                if (sm_valid !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL write_strobe c=%0d: got valid=%b done=%b, expected valid=1 done=0",
                             c, sm_valid, done);
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (sm_addr !== 4'(c - 1) || sm_data !== e) begin
                    errors++;
                    $display("FAIL write_data c=%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                             c, sm_addr, sm_data, c - 1, e);
                end
            end else begin
                checks++;
                if (sm_valid !== 1'b0 || done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_state c=%0d: got valid=%b done=%b, expected valid=0 done=1",
                             c, sm_valid, done);
                end
            end
        end
        um_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        um_valid = 1'b0;
        um_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (sm_valid !== 1'b0 || sm_addr !== 4'd0 || sm_data !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b addr=%0d data=%h done=%b, expected all 0",
                     sm_valid, sm_addr, sm_data, done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reverse_input();
        vec_t v, a;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            v[i] = 32'(N - 1 - i);
            a[i] = 32'(i);
        end
        push_expected(a, 1'b1);
        drive_job(v, 1'b0);
        collect(1'b0);
    endtask

    task automatic test_mixed_extremes();
        vec_t v, a;
        apply_reset();
        v[0] = 32'hFFFF_FFFF; v[1] = 32'h0000_0000; v[2] = 32'h8000_0000; v[3] = 32'h7FFF_FFFF;
        for (int i = 4; i < N; i++) v[i] = 32'h5;
        a[0] = 32'h0;
        for (int i = 1; i <= 12; i++) a[i] = 32'h5;
        a[13] = 32'h7FFF_FFFF; a[14] = 32'h8000_0000; a[15] = 32'hFFFF_FFFF;
        push_expected(a, 1'b1);
        drive_job(v, 1'b0);
        collect(1'b0);
    endtask

    task automatic test_gaps_random();
        vec_t v;
        apply_reset();
        for (int i = 0; i < N; i++) v[i] = $urandom;
        v[5] = v[2];
        push_expected(v, 1'b0);
        drive_job(v, 1'b1);
        collect(1'b1);
    endtask

    task automatic test_abort();
        vec_t v;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            um_valid = 1'b1;
            um_data  = 32'hFFFF_0000 + 32'(i);
            checks++;
            if (done !== 1'b0 || sm_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_load_idle i=%0d: got done=%b valid=%b, expected 0 0",
                         i, done, sm_valid);
            end
            @(posedge clk);
        end
        @(negedge clk);
        um_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sm_valid !== 1'b0 || sm_addr !== 4'd0 || sm_data !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got valid=%b addr=%0d data=%h done=%b, expected all 0",
                     sm_valid, sm_addr, sm_data, done);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) v[i] = 32'(((i * 7) % N) + 100);
        push_expected(v, 1'b0);
        drive_job(v, 1'b0);
        collect(1'b0);
    endtask

    task automatic test_all_equal();
        vec_t v;
        apply_reset();
        for (int i = 0; i < N; i++) v[i] = 32'hA5A5_A5A5;
        push_expected(v, 1'b1);
        drive_job(v, 1'b0);
        collect(1'b0);
    endtask

    task automatic test_ascending_input();
        vec_t v;
        apply_reset();
        for (int i = 0; i < N; i++) v[i] = 32'(i);
        push_expected(v, 1'b1);
        drive_job(v, 1'b0);
        collect(1'b0);
    endtask

    initial begin
        test_reset();
        test_reverse_input();
        test_mixed_extremes();
        test_gaps_random();
        test_abort();
        test_all_equal();
        test_ascending_input();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
